// File: rtl/bitcell_pkg.sv
// Shared types and helpers for the bitcell memory arbiter slice.
package bitcell_pkg;

  // Sequencer states for one array access.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // Requester operation codes carried on the we lines.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Modular add used for round-robin index arithmetic.
  function automatic int wrap_add(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr, wrapping.
module rr_arbiter
  import bitcell_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IW-1:0]    win_idx,
  output logic             any_req
);

  // rot_idx[k] is the requester examined k-th when searching from ptr.
  logic [IW-1:0]    rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_req;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_idx[gi] = IW'(wrap_add(int'(ptr), gi, N_REQ));
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the closest request to ptr wins last.
  always_comb begin
    win_idx    = ptr;
    win_onehot = '0;
    any_req    = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_idx = rot_idx[i];
      end
    end
    if (any_req) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bitcell_mem_arbiter.sv
// Shares one bitcell array between N_REQ clients: round-robin grant, then a
// fixed SETUP / ACCESS x ACCESS_CYCLES / DONE sequence on the array lines.
module bitcell_mem_arbiter
  import bitcell_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int AW            = 3,
  parameter int DW            = 4,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                cell_sel,
  output logic                cell_we,
  output logic [AW-1:0]       cell_addr,
  output logic [DW-1:0]       cell_wdata,
  input  logic [DW-1:0]       cell_rdata
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(ACCESS_CYCLES + 1);

  // Per-requester views of the packed address/data buses.
  logic [AW-1:0] addr_arr  [N_REQ];
  logic [DW-1:0] wdata_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*AW +: AW];
      assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [IW-1:0]     ptr_reg;
  logic [N_REQ-1:0]  win_oh_reg;
  logic [IW-1:0]     win_idx_reg;
  logic              we_reg;
  logic [AW-1:0]     addr_reg;
  logic [DW-1:0]     wdata_reg;
  logic [DW-1:0]     rdata_reg;
  logic [CW-1:0]     cnt_reg;

  logic [N_REQ-1:0]  arb_oh;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              access_last;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req        (req),
    .ptr        (ptr_reg),
    .win_onehot (arb_oh),
    .win_idx    (arb_idx),
    .any_req    (arb_any)
  );

  assign access_last = (cnt_reg == CW'(ACCESS_CYCLES - 1));
  assign cell_addr   = addr_reg;
  assign cell_wdata  = wdata_reg;
  assign rdata       = rdata_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and phase-decoded array/handshake outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    gnt        = '0;
    ack        = '0;
    cell_sel   = 1'b0;
    cell_we    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        busy       = 1'b1;
        gnt        = win_oh_reg;
        cell_sel   = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy     = 1'b1;
        gnt      = win_oh_reg;
        cell_sel = 1'b1;
        cell_we  = (we_reg == OP_WRITE);
        if (access_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        gnt        = win_oh_reg;
        ack        = win_oh_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the winner's command at grant; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_oh_reg  <= '0;
      win_idx_reg <= '0;
      we_reg      <= OP_READ;
      addr_reg    <= '0;
      wdata_reg   <= '0;
    end else if (state_reg == ST_IDLE && arb_any) begin
      win_oh_reg  <= arb_oh;
      win_idx_reg <= arb_idx;
      we_reg      <= we[arb_idx];
      addr_reg    <= addr_arr[arb_idx];
      wdata_reg   <= wdata_arr[arb_idx];
    end
  end

  // ACCESS phase counter, cleared on the SETUP->ACCESS edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_SETUP) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS && !access_last) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Read data is taken on the last ACCESS edge and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (state_reg == ST_ACCESS && access_last && we_reg == OP_READ) begin
      rdata_reg <= cell_rdata;
    end
  end

  // Pointer moves past the winner once its transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      ptr_reg <= IW'(wrap_add(int'(win_idx_reg), 1, N_REQ));
    end
  end

endmodule

// File: tb/tb_bitcell_mem_arbiter.sv
// Bench: two arbiters (ACCESS_CYCLES 1 and 3) on behavioural bitcell arrays,
// compared every cycle against a transaction-level model plus directed checks.
module tb_bitcell_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;

  logic [1:0] req   [2];
  logic [1:0] we    [2];
  logic [5:0] addr  [2];
  logic [7:0] wdata [2];
  logic [1:0] gnt   [2];
  logic [1:0] ack   [2];
  logic [3:0] rdata [2];
  logic       busy  [2];
  logic       cell_sel [2];
  logic       cell_we  [2];
  logic [2:0] cell_addr  [2];
  logic [3:0] cell_wdata [2];
  logic [3:0] cell_rdata [2];
  logic [3:0] arr [2][8];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic int ac_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] init_word(input int d, input int a);
    return 4'(a * 3 + d + 1);
  endfunction

  function automatic logic [1:0] onehot(input int w);
    logic [1:0] v;
    v = 2'b01 << w;
    return v;
  endfunction

  function automatic int pick(input logic [1:0] r, input int p);
    for (int i = 0; i < 2; i++) begin
      int j;
      j = (p + i) % 2;
      if (r[j]) return j;
    end
    return p;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
  endtask

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      bitcell_mem_arbiter #(
        .N_REQ(2), .AW(3), .DW(4), .ACCESS_CYCLES(gi == 0 ? 1 : 3)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req[gi]), .we(we[gi]), .addr(addr[gi]),
        .wdata(wdata[gi]), .gnt(gnt[gi]), .ack(ack[gi]), .rdata(rdata[gi]),
        .busy(busy[gi]), .cell_sel(cell_sel[gi]), .cell_we(cell_we[gi]),
        .cell_addr(cell_addr[gi]), .cell_wdata(cell_wdata[gi]),
        .cell_rdata(cell_rdata[gi])
      );
      assign cell_rdata[gi] = arr[gi][cell_addr[gi]];
    end
  endgenerate

  // Behavioural bitcell arrays seen by the DUTs.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int a = 0; a < 8; a++) arr[d][a] <= init_word(d, a);
      end else if (cell_sel[d] && cell_we[d]) begin
        arr[d][cell_addr[d]] <= cell_wdata[d];
      end
    end
  end

  // Transaction model: m_k counts edges since grant (0 setup, 1..AC access, AC+1 done).
  bit         m_act [2];
  int         m_k   [2];
  int         m_win [2];
  int         m_ptr [2];
  logic       m_we  [2];
  logic [2:0] m_addr [2];
  logic [3:0] m_wd  [2];
  logic [3:0] m_rd  [2];
  logic [3:0] m_mem [2][8];

  // Model update on each clock edge or reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0; m_k[d] <= 0; m_win[d] <= 0; m_ptr[d] <= 0;
        m_we[d] <= 1'b0; m_addr[d] <= '0; m_wd[d] <= '0; m_rd[d] <= '0;
        for (int a = 0; a < 8; a++) m_mem[d][a] <= init_word(d, a);
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_act[d]) begin
          if (m_k[d] == ac_of(d)) begin
            if (m_we[d]) m_mem[d][m_addr[d]] <= m_wd[d];
            else         m_rd[d] <= m_mem[d][m_addr[d]];
          end
          if (m_k[d] == ac_of(d) + 1) begin
            m_act[d] <= 1'b0;
            m_ptr[d] <= (m_win[d] + 1) % 2;
          end
          m_k[d] <= m_k[d] + 1;
        end else if (req[d] != 2'b00) begin
          m_act[d]  <= 1'b1;
          m_k[d]    <= 0;
          m_win[d]  <= pick(req[d], m_ptr[d]);
          m_we[d]   <= we[d][pick(req[d], m_ptr[d])];
          m_addr[d] <= addr[d][pick(req[d], m_ptr[d])*3 +: 3];
          m_wd[d]   <= wdata[d][pick(req[d], m_ptr[d])*4 +: 4];
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, busy[d], m_act[d]);
        chk("gnt", d, gnt[d], m_act[d] ? onehot(m_win[d]) : 2'b00);
        chk("ack", d, ack[d], (m_act[d] && m_k[d] == ac_of(d) + 1) ? onehot(m_win[d]) : 2'b00);
        chk("cell_sel", d, cell_sel[d], m_act[d] && m_k[d] <= ac_of(d));
        chk("cell_we", d, cell_we[d], m_act[d] && m_k[d] >= 1 && m_k[d] <= ac_of(d) && m_we[d]);
        chk("cell_addr", d, cell_addr[d], m_addr[d]);
        chk("cell_wdata", d, cell_wdata[d], m_wd[d]);
        chk("rdata", d, rdata[d], m_rd[d]);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req[0] = 2'b00;
    req[1] = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single-requester transaction; reports latency and phase cycle counts.
  task automatic txn(input int d, input int r, input logic w, input logic [2:0] a,
                     input logic [3:0] wd, output int lat, output int we_hi,
                     output int sel_hi, output int acks, output logic [3:0] rd);
    lat = 0; we_hi = 0; sel_hi = 0; acks = 0; rd = '0;
    we[d][r] = w;
    addr[d][r*3 +: 3] = a;
    wdata[d][r*4 +: 4] = wd;
    req[d][r] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (cell_we[d]) we_hi++;
      if (cell_sel[d]) sel_hi++;
      if (ack[d][r]) begin
        acks++;
        if (lat == 0) lat = n;
        rd = rdata[d];
        req[d][r] = 1'b0;
      end
      if (acks > 0 && !busy[d]) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    int lat, weh, selh, acks, t0, t1, cnt;
    logic [3:0] rd, rd0, rd1;
    logic [1:0] g_first;
    logic [1:0] g [6];
    logic pb;

    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_gnt", 0, gnt[0], 2'b00);
    chk("rst_rdata", 0, rdata[0], 4'h0);
    chk("rst_cell_addr", 0, cell_addr[0], 3'd0);

    // Write then read back on requester 0
    txn(0, 0, 1'b1, 3'd5, 4'hA, lat, weh, selh, acks, rd);
    chk("wr_ack_cycle", 0, lat, 3);
    chk("wr_we_cycles", 0, weh, 1);
    chk("wr_ack_count", 0, acks, 1);
    txn(0, 0, 1'b0, 3'd5, 4'h0, lat, weh, selh, acks, rd);
    chk("rd_ack_cycle", 0, lat, 3);
    chk("rd_data", 0, rd, 4'hA);
    chk("rd_sel_cycles", 0, selh, 2);
    chk("rd_we_cycles", 0, weh, 0);

    // Simultaneous reads right after reset
    do_reset();
    addr[0] = {3'd2, 3'd1};
    we[0] = 2'b00;
    req[0] = 2'b11;
    g_first = 2'b00; t0 = 0; t1 = 0; rd0 = '0; rd1 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (g_first == 2'b00 && busy[0]) g_first = gnt[0];
      if (ack[0][0]) begin t0 = n; rd0 = rdata[0]; req[0][0] = 1'b0; end
      if (ack[0][1]) begin t1 = n; rd1 = rdata[0]; req[0][1] = 1'b0; end
      if (t0 != 0 && t1 != 0 && !busy[0]) break;
    end
    chk("sim_first_gnt", 0, g_first, 2'b01);
    chk("sim_ack0_cycle", 0, t0, 3);
    chk("sim_ack_spacing", 0, t1 - t0, 4);
    chk("sim_rd0", 0, rd0, 4'h4);
    chk("sim_rd1", 0, rd1, 4'h7);

    // Continuous contention: six grants must alternate
    addr[0] = {3'd6, 3'd0};
    req[0] = 2'b11;
    cnt = 0;
    pb = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (busy[0] && !pb && cnt < 6) begin
        g[cnt] = gnt[0];
        cnt++;
        if (cnt == 6) req[0] = 2'b00;
      end
      pb = busy[0];
      if (cnt == 6 && !busy[0]) break;
    end
    chk("alt_grant_count", 0, cnt, 6);
    for (int i = 0; i < 6; i++) begin
      chk("alt_grant", 0, g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Inputs change and req drops after grant
    we[0][0] = 1'b0;
    addr[0][2:0] = 3'd2;
    req[0][0] = 1'b1;
    acks = 0;
    rd = '0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) begin
        addr[0][2:0] = 3'd6;
        req[0][0] = 1'b0;
      end
      if (busy[0]) chk("hold_addr", 0, cell_addr[0], 3'd2);
      if (ack[0][0]) begin acks++; rd = rdata[0]; end
    end
    chk("drop_ack_count", 0, acks, 1);
    chk("drop_rdata", 0, rd, 4'h7);

    // Longer access phase
    txn(1, 1, 1'b0, 3'd4, 4'h0, lat, weh, selh, acks, rd);
    chk("ac3_rd_ack_cycle", 1, lat, 5);
    chk("ac3_rd_sel_cycles", 1, selh, 4);
    chk("ac3_rd_data", 1, rd, 4'hE);
    txn(1, 0, 1'b1, 3'd4, 4'h3, lat, weh, selh, acks, rd);
    chk("ac3_wr_ack_cycle", 1, lat, 5);
    chk("ac3_wr_we_cycles", 1, weh, 3);
    txn(1, 1, 1'b0, 3'd4, 4'h0, lat, weh, selh, acks, rd);
    chk("ac3_rdback", 1, rd, 4'h3);

    // Asynchronous reset in the middle of a write access
    we[0][0] = 1'b1;
    addr[0][2:0] = 3'd3;
    wdata[0][3:0] = 4'h5;
    req[0][0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    chk("pre_rst_we", 0, cell_we[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 0, cell_we[0], 1'b0);
    chk("async_rst_sel", 0, cell_sel[0], 1'b0);
    chk("async_rst_gnt", 0, gnt[0], 2'b00);
    chk("async_rst_busy", 0, busy[0], 1'b0);
    req[0] = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we[0] = 2'b00;
    req[0] = 2'b11;
    @(posedge clk);
    #1;
    chk("post_rst_winner", 0, gnt[0], 2'b01);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (ack[0][0]) req[0][0] = 1'b0;
      if (ack[0][1]) req[0][1] = 1'b0;
      if (req[0] == 2'b00 && !busy[0]) break;
    end
    chk("post_rst_drain", 0, req[0], 2'b00);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
